// File: rtl/char_input_queue.sv
// char_input_queue: character front end for segment_animator.
// Synchronises the raw strobe and its code and turns each strobe rising edge
// into at most one accepted character. A tick60 lockout filters switch
// bounce. Accepted codes sit in a small first-word-fall-through FIFO that is
// read over a valid/ready handshake.

module char_input_queue #(
  parameter int WIDTH         = 7,
  parameter int DEPTH         = 4,
  parameter int LOCKOUT_TICKS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     tick60,
  input  logic                     strobe_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     char_ready,
  output logic                     char_valid,
  output logic [WIDTH-1:0]         char_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // The lockout counter needs to hold LOCKOUT_TICKS; keep at least one bit
  // so the zero-lockout build still has a legal (always-zero) register.
  localparam int LOCK_W = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;

  localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCKOUT_TICKS);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

  // ---------------------------------------------------------------------
  // Synchroniser state
  // ---------------------------------------------------------------------
  logic             s1_reg;
  logic             s2_reg;
  logic             s3_reg;
  logic [WIDTH-1:0] d1_reg;
  logic [WIDTH-1:0] d2_reg;

  // ---------------------------------------------------------------------
  // Lockout and FIFO control state
  // ---------------------------------------------------------------------
  logic [LOCK_W-1:0] lock_cnt_reg;
  logic [LOCK_W-1:0] lock_cnt_next;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              overflow_reg;
  logic              overflow_next;

  // Storage: one register per entry, gathered into an array for the read mux.
  logic [WIDTH-1:0]  entries [DEPTH];

  // ---------------------------------------------------------------------
  // Decoded control
  // ---------------------------------------------------------------------
  logic edge_det;
  logic locked;
  logic push_req;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic wr_en;
  logic drop;

  assign edge_det   = s2_reg & ~s3_reg;
  assign locked     = (lock_cnt_reg != '0);
  // An edge is accepted only while enabled and out of lockout; edges inside
  // the lockout window vanish without touching the FIFO or overflow.
  assign push_req   = enable & edge_det & ~locked;
  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);
  assign pop        = enable & ~fifo_empty & char_ready;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the write can proceed in the same cycle.
  assign wr_en      = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;

  // Two-flop synchroniser plus history flop; runs even when disabled so that
  // edges occurring while disabled are consumed rather than replayed later.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
      d1_reg <= '0;
      d2_reg <= '0;
    end else begin
      s1_reg <= strobe_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
      d1_reg <= data_in;
      d2_reg <= d1_reg;
    end
  end

  // Next-state for lockout counter, pointers, occupancy and sticky overflow.
  always_comb begin
    lock_cnt_next = lock_cnt_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (enable) begin
      // A fresh acceptance reloads the counter and takes priority over a
      // coincident tick60, so the full window is always honoured.
      if (push_req) begin
        lock_cnt_next = LOCK_INIT;
      end else if (tick60 && locked) begin
        lock_cnt_next = lock_cnt_reg - LOCK_ONE;
      end

      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end

      unique case ({wr_en, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase

      if (drop) begin
        overflow_next = 1'b1;
      end
    end
  end

  // Control registers; reset flushes the queue and clears the sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      lock_cnt_reg <= lock_cnt_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Per-entry storage; contents need no reset because occupancy gates reads.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      // Capture the aligned code when this slot is the write target.
      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= d2_reg;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  // Outputs are decoded purely from registers: no path from char_ready.
  assign char_valid = ~fifo_empty;
  assign char_out   = fifo_empty ? '0 : entries[rd_ptr_reg];
  assign count      = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_char_input_queue.sv
// Directed bench for char_input_queue: latency, lockout, overflow,
// full push+pop, reset flush, enable freeze and a streaming order check.

module tb_char_input_queue;

  localparam int WIDTH = 7;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             tick60;
  logic             strobe_in;
  logic [WIDTH-1:0] data_in;
  logic             char_ready;
  logic             char_valid;
  logic [WIDTH-1:0] char_out;
  logic [2:0]       count;
  logic             overflow;

  int tests = 0;
  int fails = 0;

  // Streaming-phase scoreboard state.
  logic             stream_mode = 1'b0;
  logic             drain       = 1'b0;
  logic [WIDTH-1:0] exp_q [$];

  char_input_queue #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .LOCKOUT_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .tick60(tick60),
    .strobe_in(strobe_in),
    .data_in(data_in),
    .char_ready(char_ready),
    .char_valid(char_valid),
    .char_out(char_out),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge. In streaming
  // mode, a handshake about to complete is checked against the model first.
  task automatic tick();
    logic [WIDTH-1:0] head;
    if (stream_mode && char_valid && char_ready) begin
      if (exp_q.size() == 0) begin
        check("t6_pop_unexpected", 32'(char_out), 32'hFFFF_FFFF);
      end else begin
        head = exp_q.pop_front();
        check("t6_order", 32'(char_out), 32'(head));
      end
    end
    @(posedge clk);
    #1;
    if (stream_mode) begin
      check("t6_count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
      char_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_tick60();
    tick60 = 1'b1;
    tick();
    tick60 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  // Strobe high for 4 clks with the code held, then low for 3 clks.
  task automatic press(input logic [WIDTH-1:0] code);
    data_in   = code;
    strobe_in = 1'b1;
    ticks(4);
    strobe_in = 1'b0;
    ticks(3);
  endtask

  // Three tick60 pulses clear any running lockout before the press.
  task automatic press_unlocked(input logic [WIDTH-1:0] code);
    for (int i = 0; i < 3; i++) pulse_tick60();
    press(code);
  endtask

  task automatic pop_check(input string tag, input logic [WIDTH-1:0] code);
    check({tag, "_valid"}, 32'(char_valid), 32'd1);
    check({tag, "_data"}, 32'(char_out), 32'(code));
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
  endtask

  initial begin
    int guard;
    reset      = 1'b1;
    enable     = 1'b1;
    tick60     = 1'b0;
    strobe_in  = 1'b0;
    data_in    = '0;
    char_ready = 1'b0;
    ticks(2);
    reset = 1'b0;
    tick();

    // T1: reset state and first-character latency
    check("t1_rst_valid", 32'(char_valid), 32'd0);
    check("t1_rst_count", 32'(count), 32'd0);
    check("t1_rst_overflow", 32'(overflow), 32'd0);
    check("t1_rst_char_out", 32'(char_out), 32'd0);
    data_in   = 7'h2A;
    strobe_in = 1'b1;
    tick();
    check("t1_valid_clk1", 32'(char_valid), 32'd0);
    tick();
    check("t1_valid_clk2", 32'(char_valid), 32'd0);
    tick();
    check("t1_valid_clk3", 32'(char_valid), 32'd1);
    check("t1_char_out", 32'(char_out), 32'h2A);
    check("t1_count", 32'(count), 32'd1);
    ticks(7);
    strobe_in = 1'b0;
    ticks(3);
    check("t1_count_after", 32'(count), 32'd1);

    // T2: lockout (counter is 3 after the T1 acceptance)
    pulse_tick60();
    pulse_tick60();
    press(7'h11);
    check("t2_locked_count", 32'(count), 32'd1);
    check("t2_locked_overflow", 32'(overflow), 32'd0);
    check("t2_head_kept", 32'(char_out), 32'h2A);
    pulse_tick60();
    press(7'h22);
    check("t2_unlocked_count", 32'(count), 32'd2);

    // T3: overflow on the fifth press, then in-order drain
    do_reset();
    for (int k = 1; k <= 5; k++) press_unlocked(7'(k));
    check("t3_count_full", 32'(count), 32'd4);
    check("t3_overflow", 32'(overflow), 32'd1);
    pop_check("t3_pop1", 7'd1);
    pop_check("t3_pop2", 7'd2);
    pop_check("t3_pop3", 7'd3);
    pop_check("t3_pop4", 7'd4);
    check("t3_empty_valid", 32'(char_valid), 32'd0);
    check("t3_empty_char_out", 32'(char_out), 32'd0);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // T4: full FIFO, push and pop in the same cycle
    do_reset();
    for (int k = 1; k <= 4; k++) press_unlocked(7'(k));
    check("t4_count_full", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) pulse_tick60();
    data_in   = 7'h09;
    strobe_in = 1'b1;
    ticks(2);
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    check("t4_count_same", 32'(count), 32'd4);
    check("t4_no_overflow", 32'(overflow), 32'd0);
    check("t4_new_head", 32'(char_out), 32'd2);
    tick();
    strobe_in = 1'b0;
    ticks(3);
    pop_check("t4_pop2", 7'd2);
    pop_check("t4_pop3", 7'd3);
    pop_check("t4_pop4", 7'd4);
    pop_check("t4_pop9", 7'h09);
    check("t4_empty_valid", 32'(char_valid), 32'd0);
    check("t4_overflow_end", 32'(overflow), 32'd0);

    // T5: reset flushes the queue; disabled presses are lost
    do_reset();
    press_unlocked(7'h41);
    press_unlocked(7'h42);
    check("t5_count_two", 32'(count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_flush_valid", 32'(char_valid), 32'd0);
    check("t5_flush_count", 32'(count), 32'd0);
    check("t5_flush_overflow", 32'(overflow), 32'd0);
    enable = 1'b0;
    press(7'h55);
    enable = 1'b1;
    ticks(3);
    check("t5_disabled_count", 32'(count), 32'd0);
    check("t5_disabled_valid", 32'(char_valid), 32'd0);
    press_unlocked(7'h66);
    check("t5_enabled_count", 32'(count), 32'd1);
    enable     = 1'b0;
    char_ready = 1'b1;
    ticks(3);
    check("t5_frozen_count", 32'(count), 32'd1);
    check("t5_frozen_char_out", 32'(char_out), 32'h66);
    char_ready = 1'b0;
    enable     = 1'b1;

    // T6: streaming across pointer wrap with random char_ready
    do_reset();
    exp_q.delete();
    char_ready  = 1'($urandom_range(0, 1));
    stream_mode = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      exp_q.push_back(7'(8'h10 + i));
      press_unlocked(7'(8'h10 + i));
    end
    drain = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      tick();
      guard++;
    end
    stream_mode = 1'b0;
    drain       = 1'b0;
    char_ready  = 1'b0;
    check("t6_all_popped", 32'(exp_q.size()), 32'd0);
    check("t6_empty_valid", 32'(char_valid), 32'd0);
    check("t6_overflow", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
